// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one SDRAM request port, one transaction in flight
module mem_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_din,
  output logic                  p0_ack,
  output logic                  p0_valid,
  output logic [DATA_WIDTH-1:0] p0_dout,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_din,
  output logic                  p1_ack,
  output logic                  p1_valid,
  output logic [DATA_WIDTH-1:0] p1_dout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  grant,
  output logic                  busy
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, READ = 2'd2;
  logic [1:0] state;
  logic last_grant;
  logic win;
  logic take;
  // on a tie the port that did not win last time gets the memory
  assign win = (p0_req && p1_req) ? ~last_grant : p1_req;
  assign take = (state == REQ && mem_ack && !mem_we && mem_valid) || (state == READ && mem_valid);
  assign mem_req = state == REQ;
  assign busy = state != IDLE;
  assign p0_ack = mem_ack && state == REQ && !grant;
  assign p1_ack = mem_ack && state == REQ && grant;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
      p0_dout <= '0;
      p1_dout <= '0;
    end else begin
      p0_valid <= take && !grant;
      p1_valid <= take && grant;
      if (take && !grant) p0_dout <= mem_dout;
      if (take && grant) p1_dout <= mem_dout;
      case (state)
        IDLE: if (p0_req || p1_req) begin
          state <= REQ;
          grant <= win;
          last_grant <= win;
          mem_we <= win ? p1_we : p0_we;
          mem_addr <= win ? p1_addr : p0_addr;
          mem_din <= win ? p1_din : p0_din;
        end
        REQ: if (mem_ack) state <= (mem_we || mem_valid) ? IDLE : READ;
        READ: if (mem_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a round-robin reference model
module tb_mem_arbiter;
  localparam int AW = 23, DW = 16;
  logic clock = 1'b0, reset = 1'b1;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_din = '0, p1_din = '0;
  logic p0_ack, p0_valid, p1_ack, p1_valid;
  logic [DW-1:0] p0_dout, p1_dout;
  logic mem_req, mem_we, grant, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic mem_ack = 0, mem_valid = 0;
  logic [DW-1:0] mem_dout = '0;
  int checks = 0, errors = 0;
  bit mlast = 1'b1;
  logic [DW-1:0] exp_dout [2] = '{16'h0, 16'h0};

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_ack(p0_ack), .p0_valid(p0_valid), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_ack(p1_ack), .p1_valid(p1_valid), .p1_dout(p1_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_dout(mem_dout),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic test_reset;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_din, grant, busy, p0_ack, p1_ack, p0_valid, p1_valid, p0_dout, p1_dout} !== '0) begin
      errors++;
      $display("FAIL reset_values got %h required 0", {mem_req, mem_we, mem_addr, mem_din, grant, busy, p0_ack, p1_ack, p0_valid, p1_valid, p0_dout, p1_dout});
    end
    reset = 0;
    @(negedge clock);
    #1;
    checks++;
    if ({busy, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got busy/mem_req %b required 00", {busy, mem_req});
    end
  endtask

  // One complete transaction; the model picks the winner from the round-robin rule.
  task automatic txn(input bit r0, input bit r1, input bit we0, input bit we1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input int alat, input int vlat, input logic [DW-1:0] rd, output bit w);
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = (r0 && r1) ? !mlast : r1;
    mlast = w;
    we = w ? we1 : we0;
    a = w ? a1 : a0;
    d = w ? d1 : d0;
    @(negedge clock);
    p0_req = r0; p0_we = we0; p0_addr = a0; p0_din = d0;
    p1_req = r1; p1_we = we1; p1_addr = a1; p1_din = d1;
    @(negedge clock);
    #1;
    checks++;
    if ({mem_req, busy, grant, mem_we, mem_addr, mem_din} !== {2'b11, w, we, a, d}) begin
      errors++;
      $display("FAIL issue got req/busy/grant/we/addr/din %b %b %b %b %h %h required 1 1 %b %b %h %h",
               mem_req, busy, grant, mem_we, mem_addr, mem_din, w, we, a, d);
    end
    for (int i = 0; i < alat; i++) begin
      checks++;
      if ({p0_ack, p1_ack, mem_req} !== 3'b001) begin
        errors++;
        $display("FAIL wait_ack got ack0/ack1/mem_req %b required 001", {p0_ack, p1_ack, mem_req});
      end
      @(negedge clock);
      #1;
    end
    mem_ack = 1;
    if (!we && vlat == 0) begin mem_valid = 1; mem_dout = rd; end
    #1;
    checks++;
    if ({p1_ack, p0_ack} !== (w ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL ack got p1/p0 %b required %b", {p1_ack, p0_ack}, w ? 2'b10 : 2'b01);
    end
    @(negedge clock);
    mem_ack = 0; mem_valid = 0; p0_req = 0; p1_req = 0;
    #1;
    if (!we && vlat > 0) begin
      for (int i = 1; i < vlat; i++) begin
        checks++;
        if ({busy, p0_valid, p1_valid} !== 3'b100) begin
          errors++;
          $display("FAIL read_wait got busy/v0/v1 %b required 100", {busy, p0_valid, p1_valid});
        end
        @(negedge clock);
        #1;
      end
      mem_valid = 1;
      mem_dout = rd;
      @(negedge clock);
      mem_valid = 0;
      #1;
    end
    if (!we) exp_dout[w] = rd;
    checks++;
    if ({busy, mem_req, p1_valid, p0_valid} !== {2'b00, !we && w, !we && !w}) begin
      errors++;
      $display("FAIL done got busy/mem_req/v1/v0 %b required %b", {busy, mem_req, p1_valid, p0_valid}, {2'b00, !we && w, !we && !w});
    end
    checks++;
    if ({p1_dout, p0_dout} !== {exp_dout[1], exp_dout[0]}) begin
      errors++;
      $display("FAIL dout got %h %h required %h %h", p1_dout, p0_dout, exp_dout[1], exp_dout[0]);
    end
    @(negedge clock);
    #1;
    checks++;
    if ({p1_valid, p0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL valid_pulse got %b required 00", {p1_valid, p0_valid});
    end
  endtask

  task automatic test_write;
    @(negedge clock);
    p0_req = 1; p0_we = 1; p0_addr = 23'h000010; p0_din = 16'hBEEF;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL write_latency got mem_req %b required 0", mem_req);
    end
    @(negedge clock);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_din} !== {2'b11, 23'h000010, 16'hBEEF}) begin
      errors++;
      $display("FAIL write_issue got %b %b %h %h required 1 1 000010 beef", mem_req, mem_we, mem_addr, mem_din);
    end
    mem_ack = 1;
    #1;
    checks++;
    if ({p0_ack, p1_ack} !== 2'b10) begin
      errors++;
      $display("FAIL write_ack got p0/p1 %b required 10", {p0_ack, p1_ack});
    end
    @(negedge clock);
    mem_ack = 0; p0_req = 0;
    #1;
    checks++;
    if ({busy, p0_ack} !== 2'b00) begin
      errors++;
      $display("FAIL write_idle got busy/ack %b required 00", {busy, p0_ack});
    end
    mlast = 0;
  endtask

  task automatic test_read;
    bit w;
    txn(0, 1, 0, 0, '0, 23'h123456, '0, '0, 1, 3, 16'h5A5A, w);
  endtask

  task automatic test_fairness;
    bit w;
    for (int i = 0; i < 6; i++) begin
      txn(1, 1, 1, 1, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(0, 2), 0, '0, w);
      checks++;
      if (w !== bit'(i % 2)) begin
        errors++;
        $display("FAIL grant_order txn %0d got %0d required %0d", i, w, i % 2);
      end
    end
  endtask

  task automatic test_same_cycle;
    bit w;
    txn(1, 0, 0, 0, 23'h000020, '0, '0, '0, 0, 0, 16'h1234, w);
  endtask

  task automatic test_reset_mid;
    bit w;
    @(negedge clock);
    p1_req = 1; p1_we = 0; p1_addr = 23'h0000AA;
    @(negedge clock);
    mem_ack = 1;
    @(negedge clock);
    mem_ack = 0; p1_req = 0;
    #1;
    checks++;
    if ({busy, mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_read got busy/mem_req %b required 10", {busy, mem_req});
    end
    reset = 1;
    @(negedge clock);
    reset = 0; mem_valid = 1; mem_dout = 16'hDEAD;
    @(negedge clock);
    mem_valid = 0;
    #1;
    exp_dout[0] = '0; exp_dout[1] = '0; mlast = 1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_din, grant, busy, p0_ack, p1_ack, p0_valid, p1_valid, p0_dout, p1_dout} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h required 0", {mem_req, mem_we, mem_addr, mem_din, grant, busy, p0_ack, p1_ack, p0_valid, p1_valid, p0_dout, p1_dout});
    end
    txn(1, 1, 1, 0, 23'h000001, 23'h000002, 16'h1111, '0, 0, 1, 16'h2222, w);
    checks++;
    if (w !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie got %0d required 0", w);
    end
  endtask

  task automatic test_stray;
    @(negedge clock);
    mem_ack = 1; mem_valid = 1; mem_dout = 16'hFFFF;
    #1;
    checks++;
    if ({p0_ack, p1_ack} !== 2'b00) begin
      errors++;
      $display("FAIL stray_ack got %b required 00", {p0_ack, p1_ack});
    end
    @(negedge clock);
    mem_ack = 0; mem_valid = 0;
    #1;
    checks++;
    if ({busy, mem_req, p0_valid, p1_valid, p0_dout, p1_dout} !== {4'b0000, exp_dout[0], exp_dout[1]}) begin
      errors++;
      $display("FAIL stray_state got %b %h %h required 0000 %h %h", {busy, mem_req, p0_valid, p1_valid}, p0_dout, p1_dout, exp_dout[0], exp_dout[1]);
    end
  endtask

  task automatic test_random;
    bit w, r0, r1;
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      txn(r0, r1, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), DW'($urandom), w);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_fairness;
    test_same_cycle;
    test_reset_mid;
    test_stray;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single SDRAM controller request port between the bridge download path (port 0, ROM writes from the data-slot loader) and the game core (port 1, ROM/tile reads). It sits between the requesters and the SDRAM controller in the `sys_clock` domain. It allows one outstanding transaction at a time. It registers the winning request onto the memory side and routes acknowledge and read data back to the granted port only.

## Interface
- `ADDR_WIDTH`, 23, word address width on all ports
- `DATA_WIDTH`, 16, data width on all ports

- `clock` in 1: system clock (`sys_clock`)
- `reset` in 1: synchronous, active-high
- `p0_req` in 1: port 0 request; held high until `p0_ack`
- `p0_we` in 1: port 0 write (1) / read (0); stable while `p0_req`
- `p0_addr` in ADDR_WIDTH: port 0 address; stable while `p0_req`
- `p0_din` in DATA_WIDTH: port 0 write data; stable while `p0_req`
- `p0_ack` out 1: request accepted by memory (combinational)
- `p0_valid` out 1: one-cycle read-data strobe (registered)
- `p0_dout` out DATA_WIDTH: read data, valid with `p0_valid`
- `p1_req`, `p1_we`, `p1_addr`, `p1_din`, `p1_ack`, `p1_valid`, `p1_dout`: same as port 0
- `mem_req` out 1: request to SDRAM controller
- `mem_we` out 1: registered copy of granted `we`
- `mem_addr` out ADDR_WIDTH: registered copy of granted address
- `mem_din` out DATA_WIDTH: registered copy of granted write data
- `mem_ack` in 1: controller accepted current request
- `mem_valid` in 1: controller read data valid
- `mem_dout` in DATA_WIDTH: controller read data
- `grant` out 1: port currently owning the memory (0/1)
- `busy` out 1: high in any state other than IDLE

## Operation
- States: IDLE, REQ, READ.
- IDLE:
  - If any `pN_req` is high, choose a winner, latch its `we/addr/din` into `mem_*`, set `grant`, and go to REQ.
  - If only one port requests, that port wins.
  - If both request, the port not equal to `last_grant` wins (round-robin).
  - `last_grant` updates on every grant. Its reset value is 1, so port 0 wins the first tie.
- REQ:
  - `mem_req` = 1.
  - Wait for `mem_ack`. On `mem_ack`, `p[grant]_ack` = 1 in the same cycle (combinational `mem_ack & state==REQ & grant==N`).
  - Write: go to IDLE.
  - Read: go to READ. If `mem_valid` is also high in the same cycle, capture the data, pulse valid next cycle, and go directly to IDLE.
- READ:
  - Wait for `mem_valid`. On `mem_valid`, register `mem_dout` into `p[grant]_dout`, pulse `p[grant]_valid` for one cycle, and go to IDLE.
- Requesters must deassert `req` (or present a new transaction) in the cycle after `ack`. The arbiter never samples `req` in the ack cycle.
- Ignored inputs:
  - `mem_ack` outside REQ.
  - `mem_valid` outside REQ/READ.
  - `pN_req` changes while not in IDLE.
- The non-granted port's `ack` and `valid` are always 0. Its `dout` holds its last value.

## Timing
- Reset values:
  - State IDLE, `last_grant` 1.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_din` all 0.
  - `grant` 0, `busy` 0, all `ack`/`valid` 0, all `dout` 0.
- Reset mid-transaction abandons it. No `ack`/`valid` is issued afterwards; late `mem_valid` is ignored.
- Request latency: `req` sampled high at edge N gives `mem_req` high from cycle N+1.
- Write throughput: `mem_ack` in cycle M means IDLE at M+1. The next request can appear on `mem_req` at M+2, so a stream needs at least 2 cycles per transaction plus controller latency.
- Read return: `mem_valid` in cycle V gives `pN_valid` and `pN_dout` in cycle V+1, and IDLE at V+1.
- A request held indefinitely stays in REQ. There is no timeout.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1.

## Test plan
- Single write on port 0 (addr 0x000010, data 0xBEEF):
  - `mem_req`=1 one cycle after `p0_req`, with `mem_we`=1, `mem_addr`=0x000010, `mem_din`=0xBEEF.
  - `p0_ack` coincides with `mem_ack`.
  - `busy` drops the next cycle.
- Single read on port 1 (addr 0x123456), controller returns 0x5A5A three cycles after ack:
  - `p1_valid`=1 for exactly one cycle, one cycle after `mem_valid`, with `p1_dout`=0x5A5A.
  - `p0_valid` stays 0.
- Both ports request simultaneously and continuously for 6 transactions:
  - Grant order is 0,1,0,1,0,1.
  - Each `ack` goes only to the granted port.
- Read with `mem_ack` and `mem_valid` in the same cycle (data 0x1234):
  - `p0_valid` pulses the next cycle with 0x1234.
  - State is IDLE the same cycle, with no stall in READ.
- Reset asserted while in READ, then `mem_valid` pulsed after release:
  - No `pN_valid` is produced.
  - All outputs hold their reset values.
  - The first post-reset tie goes to port 0.
- Stray `mem_ack`/`mem_valid` in IDLE: no `ack`, no `valid`, no state change.
